remote_update_sequencer: RTL and testbench
==========================================

# remote_update_sequencer

Sequencer between the image-select request logic and the FPGA internal-reconfiguration primitive (cfg_CBSEL / cfg_ENA / cfg_CONFIG / cfg_ERROR).
- Accepts one image-select request per handshake.
- Drives the primitive with guaranteed select setup time and a timed CONFIG pulse.
- Watches cfg_ERROR: on failure it retries the same image, then falls back to the golden image.
- Replaces free-running counter triggers that tie CBSEL and ENA to constants.

## Interface
Parameters:
- SETUP_CYCLES, 16: cycles cfg_ENA and cfg_CBSEL are stable before cfg_CONFIG rises (min 1).
- PULSE_CYCLES, 64: cfg_CONFIG high time (min 1).
- ERR_WAIT_CYCLES, 4096: post-pulse window for cfg_ERROR or device takeover (min 4).
- MAX_RETRY, 2: retries of a failing image before fallback (0..3).
- GOLDEN_SEL, 2'b00: CBSEL value of the golden image.

Ports:
- clk, in, 1: sole clock.
- rst, in, 1: synchronous, active-high reset.
- req_valid, in, 1: reconfiguration request.
- req_sel, in, 2: target image; sampled on acceptance.
- req_ready, out, 1: high only in IDLE.
- cfg_CBSEL, out, 2: image select to primitive.
- cfg_ENA, out, 1: reconfiguration enable to primitive.
- cfg_CONFIG, out, 1: reconfiguration trigger to primitive.
- cfg_ERROR, in, 1: asynchronous error from primitive.
- busy, out, 1: state is not IDLE.
- fallback, out, 1: sticky; golden image substituted.
- fail, out, 1: sticky; golden image also failed (terminal).
- retry_cnt, out, 2: retries used on the current image.

## Operation
- States: IDLE, SETUP, PULSE, WAIT, FAIL.
- IDLE
  - req_ready=1, cfg_ENA=0, cfg_CONFIG=0, cfg_CBSEL holds its last value.
  - On req_valid && req_ready: latch req_sel into sel_q, clear retry_cnt, go to SETUP.
- SETUP
  - cfg_ENA=1, cfg_CBSEL=sel_q, cfg_CONFIG=0.
  - Stay SETUP_CYCLES cycles, then go to PULSE.
- PULSE
  - cfg_CONFIG=1 for PULSE_CYCLES cycles, then go to WAIT.
- WAIT
  - cfg_CONFIG=0, cfg_ENA=1.
  - Failure = synchronized cfg_ERROR high, or ERR_WAIT_CYCLES elapsed with the device still running.
- Failure handling, in priority order:
  - retry_cnt < MAX_RETRY: retry_cnt+1, go to SETUP with the same sel_q.
  - else sel_q != GOLDEN_SEL: sel_q := GOLDEN_SEL, retry_cnt := 0, fallback := 1, go to SETUP.
  - else: fail := 1, go to FAIL.
- FAIL: cfg_ENA=0, cfg_CONFIG=0, req_ready=0. Only rst exits.
- req_sel == GOLDEN_SEL is legal. Its failure path skips fallback and goes straight to FAIL after the retries.
- cfg_ERROR passes through a 2-flop synchronizer and is only evaluated in WAIT. A high level in IDLE, SETUP or PULSE is ignored.
- fallback and fail are sticky; cleared only by rst. A new request does not clear them.

## Timing
- Reset values: state=IDLE, req_ready=1, busy=0, cfg_ENA=0, cfg_CONFIG=0, cfg_CBSEL=GOLDEN_SEL, fallback=0, fail=0, retry_cnt=0, sel_q=GOLDEN_SEL, phase counter=0, synchronizer flops=0.
- All outputs are registered; there are no combinational input-to-output paths.
- Acceptance at clock edge N: busy and cfg_ENA go high, req_ready and CBSEL=sel_q appear after edge N.
- cfg_CONFIG rises after edge N+SETUP_CYCLES and stays high exactly PULSE_CYCLES cycles.
- cfg_ERROR to failure decision: 3 cycles (2 synchronizer cycles + 1 registered decision).
- On a retry, SETUP restarts with a full SETUP_CYCLES count.
- Phase counter width: $clog2(max(SETUP_CYCLES, PULSE_CYCLES, ERR_WAIT_CYCLES)+1). It reloads to 0 on every state entry and never wraps inside a state.
- If cfg_ERROR and the timeout occur in the same cycle, count one failure only.
- rst asserted mid-sequence takes effect at the next edge: cfg_CONFIG drops to 0 immediately, with no pulse truncation guard.
- req_valid while busy is not accepted and not queued; the requester must hold it until req_ready.

## Structure
- Package remote_update_pkg holds:
  - the state enum (IDLE, SETUP, PULSE, WAIT, FAIL);
  - the default timing constants;
  - a 2-bit image-select typedef shared with the request logic.
- One sub-module, sync_2ff: a generic 1-bit two-flop synchronizer for cfg_ERROR, reusable elsewhere.
- Everything else (FSM, phase counter, retry logic) lives in one always block plus output registers.

## Test plan
- Basic: reset, then req_sel=2'b01 for 1 cycle.
  - cfg_ENA high after acceptance, cfg_CBSEL=01.
  - cfg_CONFIG high cycles 17..80 after acceptance.
  - No error and timeout reached → retry.
- Retry then fallback: sel=2'b10, cfg_ERROR held high.
  - Expect 3 CONFIG pulses on CBSEL=10 (retry_cnt 0,1,2).
  - Then fallback=1 and a pulse on CBSEL=00.
- Golden failure: continue the previous scenario with cfg_ERROR high.
  - 3 pulses on CBSEL=00, then fail=1.
  - cfg_ENA=0 and req_ready=0 until rst.
- Busy rejection: second req_valid with sel=11 during PULSE.
  - req_ready=0; CBSEL stays at the original value throughout.
- Early-error masking: cfg_ERROR pulsed high during SETUP only.
  - No retry counted; retry_cnt stays 0 entering WAIT.
- Mid-sequence reset: assert rst in cycle 30 of PULSE.
  - Next cycle: cfg_CONFIG=0, cfg_ENA=0, CBSEL=00, req_ready=1, fallback=0.

Source files
------------

// File: rtl/remote_update_pkg.sv
// Shared types and default timing for the remote-update sequencer and its request logic.
package remote_update_pkg;

    typedef logic [1:0] img_sel_t;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        PULSE = 3'd2,
        WAIT  = 3'd3,
        FAIL  = 3'd4
    } state_t;

    localparam int unsigned DEF_SETUP_CYCLES    = 16;
    localparam int unsigned DEF_PULSE_CYCLES    = 64;
    localparam int unsigned DEF_ERR_WAIT_CYCLES = 4096;
    localparam int unsigned DEF_MAX_RETRY       = 2;
    localparam img_sel_t    DEF_GOLDEN_SEL      = 2'b00;

    // Largest of three phase lengths; sizes the shared phase counter.
    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic single-bit two-flop synchronizer with synchronous active-high reset.
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;

    // Shift the asynchronous input through two stages.
    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    // Synchronizer flops.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/remote_update_sequencer.sv
// Sequences an image-select request onto the reconfiguration primitive with
// select setup, a timed CONFIG pulse, retry on failure and golden-image fallback.
module remote_update_sequencer
    import remote_update_pkg::*;
#(
    parameter int unsigned SETUP_CYCLES    = DEF_SETUP_CYCLES,
    parameter int unsigned PULSE_CYCLES    = DEF_PULSE_CYCLES,
    parameter int unsigned ERR_WAIT_CYCLES = DEF_ERR_WAIT_CYCLES,
    parameter int unsigned MAX_RETRY       = DEF_MAX_RETRY,
    parameter img_sel_t    GOLDEN_SEL      = DEF_GOLDEN_SEL
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_valid,
    input  logic [1:0] req_sel,
    output logic       req_ready,
    output logic [1:0] cfg_CBSEL,
    output logic       cfg_ENA,
    output logic       cfg_CONFIG,
    input  logic       cfg_ERROR,
    output logic       busy,
    output logic       fallback,
    output logic       fail,
    output logic [1:0] retry_cnt
);

    localparam int unsigned CNT_MAX = max3(SETUP_CYCLES, PULSE_CYCLES, ERR_WAIT_CYCLES);
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(SETUP_CYCLES - 1);
    localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] WAIT_LAST  = CNT_W'(ERR_WAIT_CYCLES - 1);
    localparam logic [1:0]       RETRY_LIM  = 2'(MAX_RETRY);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    img_sel_t         sel_q, sel_d;
    logic [1:0]       retry_q, retry_d;
    logic             fallback_q, fallback_d;
    logic             fail_q, fail_d;

    logic             req_ready_q, req_ready_d;
    logic             busy_q, busy_d;
    logic             cfg_ena_q, cfg_ena_d;
    logic             cfg_config_q, cfg_config_d;
    img_sel_t         cfg_cbsel_q, cfg_cbsel_d;

    logic             err_sync;
    logic             attempt_failed;

    sync_2ff u_err_sync (
        .clk (clk),
        .rst (rst),
        .d   (cfg_ERROR),
        .q   (err_sync)
    );

    // State, phase counter, selected image, retry and sticky status registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            sel_q      <= GOLDEN_SEL;
            retry_q    <= 2'd0;
            fallback_q <= 1'b0;
            fail_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            sel_q      <= sel_d;
            retry_q    <= retry_d;
            fallback_q <= fallback_d;
            fail_q     <= fail_d;
        end
    end

    // Next state: phase timing, acceptance, and the retry / fallback / fail ladder.
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q + CNT_W'(1);
        sel_d          = sel_q;
        retry_d        = retry_q;
        fallback_d     = fallback_q;
        fail_d         = fail_q;
        // Error and timeout landing together still count as a single failure.
        attempt_failed = err_sync || (cnt_q == WAIT_LAST);

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (req_valid && req_ready_q) begin
                    sel_d   = req_sel;
                    retry_d = 2'd0;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                if (cnt_q == SETUP_LAST) begin
                    cnt_d   = '0;
                    state_d = PULSE;
                end
            end
            PULSE: begin
                if (cnt_q == PULSE_LAST) begin
                    cnt_d   = '0;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (attempt_failed) begin
                    cnt_d = '0;
                    if (retry_q < RETRY_LIM) begin
                        retry_d = retry_q + 2'd1;
                        state_d = SETUP;
                    end else if (sel_q != GOLDEN_SEL) begin
                        sel_d      = GOLDEN_SEL;
                        retry_d    = 2'd0;
                        fallback_d = 1'b1;
                        state_d    = SETUP;
                    end else begin
                        fail_d  = 1'b1;
                        state_d = FAIL;
                    end
                end
            end
            FAIL: begin
                cnt_d = '0;
            end
            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    // Output decode from the next state so every output is a clean flop.
    always_comb begin
        req_ready_d  = (state_d == IDLE);
        busy_d       = (state_d != IDLE);
        cfg_ena_d    = (state_d == SETUP) || (state_d == PULSE) || (state_d == WAIT);
        cfg_config_d = (state_d == PULSE);
        cfg_cbsel_d  = sel_d;
    end

    // Output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            req_ready_q  <= 1'b1;
            busy_q       <= 1'b0;
            cfg_ena_q    <= 1'b0;
            cfg_config_q <= 1'b0;
            cfg_cbsel_q  <= GOLDEN_SEL;
        end else begin
            req_ready_q  <= req_ready_d;
            busy_q       <= busy_d;
            cfg_ena_q    <= cfg_ena_d;
            cfg_config_q <= cfg_config_d;
            cfg_cbsel_q  <= cfg_cbsel_d;
        end
    end

    assign req_ready  = req_ready_q;
    assign busy       = busy_q;
    assign cfg_ENA    = cfg_ena_q;
    assign cfg_CONFIG = cfg_config_q;
    assign cfg_CBSEL  = cfg_cbsel_q;
    assign fallback   = fallback_q;
    assign fail       = fail_q;
    assign retry_cnt  = retry_q;

endmodule

// File: tb/tb_remote_update_sequencer.sv
// Directed bench for remote_update_sequencer at default timing.
module tb_remote_update_sequencer;

    logic       clk;
    logic       rst;
    logic       req_valid;
    logic [1:0] req_sel;
    logic       req_ready;
    logic [1:0] cfg_CBSEL;
    logic       cfg_ENA;
    logic       cfg_CONFIG;
    logic       cfg_ERROR;
    logic       busy;
    logic       fallback;
    logic       fail;
    logic [1:0] retry_cnt;

    int n_cmp;
    int n_bad;

    logic [1:0] p_sel [8];
    logic [1:0] p_rty [8];
    logic       p_fb  [8];
    int         np;

    remote_update_sequencer #(
        .SETUP_CYCLES    (16),
        .PULSE_CYCLES    (64),
        .ERR_WAIT_CYCLES (4096),
        .MAX_RETRY       (2),
        .GOLDEN_SEL      (2'b00)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_sel    (req_sel),
        .req_ready  (req_ready),
        .cfg_CBSEL  (cfg_CBSEL),
        .cfg_ENA    (cfg_ENA),
        .cfg_CONFIG (cfg_CONFIG),
        .cfg_ERROR  (cfg_ERROR),
        .busy       (busy),
        .fallback   (fallback),
        .fail       (fail),
        .retry_cnt  (retry_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        req_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Present one request; returns at the negedge after the accepting edge.
    task automatic request(input logic [1:0] s);
        check("req_ready_before", req_ready, 1'b1);
        req_valid = 1'b1;
        req_sel   = s;
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    // Log every CONFIG pulse; stop at (stop_np, stop_off) or, with stop_np==0, at fail.
    task automatic run_pulses(input int budget, input int stop_np, input int stop_off,
                              output bit timed_out);
        int   off;
        logic prev;
        off       = 0;
        prev      = 1'b0;
        np        = 0;
        timed_out = 1'b1;
        for (int i = 0; i < budget; i++) begin
            if (cfg_CONFIG && !prev) begin
                if (np < 8) begin
                    p_sel[np] = cfg_CBSEL;
                    p_rty[np] = retry_cnt;
                    p_fb[np]  = fallback;
                end
                np++;
                off = 1;
            end else if (cfg_CONFIG) begin
                off++;
            end
            prev = cfg_CONFIG;
            if ((stop_np != 0) ? (np == stop_np && off == stop_off) : (fail === 1'b1)) begin
                timed_out = 1'b0;
                return;
            end
            @(negedge clk);
        end
    endtask

    initial begin
        int         first, last, hi, stray, rdy_seen;
        logic [1:0] r_before;
        bit         to;

        n_cmp     = 0;
        n_bad     = 0;
        rst       = 1'b1;
        req_valid = 1'b0;
        req_sel   = 2'b00;
        cfg_ERROR = 1'b0;
        r_before  = 2'b11;

        // Reset values
        do_reset();
        check("rst_ready",    req_ready,  1'b1);
        check("rst_busy",     busy,       1'b0);
        check("rst_ena",      cfg_ENA,    1'b0);
        check("rst_config",   cfg_CONFIG, 1'b0);
        check("rst_cbsel",    cfg_CBSEL,  2'b00);
        check("rst_fallback", fallback,   1'b0);
        check("rst_fail",     fail,       1'b0);
        check("rst_retry",    retry_cnt,  2'd0);

        // Basic request, pulse window, busy rejection, timeout retry
        request(2'b01);
        check("acc_ena",    cfg_ENA,    1'b1);
        check("acc_busy",   busy,       1'b1);
        check("acc_ready",  req_ready,  1'b0);
        check("acc_cbsel",  cfg_CBSEL,  2'b01);
        check("acc_config", cfg_CONFIG, 1'b0);
        first = 0; last = 0; hi = 0; stray = 0; rdy_seen = 0;
        for (int k = 1; k <= 4177; k++) begin
            if (cfg_CONFIG) begin
                if (first == 0) first = k;
                last = k;
                hi++;
            end
            if (cfg_CBSEL !== 2'b01) stray++;
            if (req_ready !== 1'b0) rdy_seen++;
            if (k == 4176) r_before = retry_cnt;
            if (k == 46) begin req_valid = 1'b1; req_sel = 2'b11; end
            if (k == 52) req_valid = 1'b0;
            if (k < 4177) @(negedge clk);
        end
        check("pulse_first",    first,     17);
        check("pulse_last",     last,      80);
        check("pulse_len",      hi,        64);
        check("busy_cbsel",     stray,     0);
        check("busy_ready",     rdy_seen,  0);
        check("timeout_before", r_before,  2'd0);
        check("timeout_retry",  retry_cnt, 2'd1);
        check("timeout_ena",    cfg_ENA,   1'b1);
        check("timeout_busy",   busy,      1'b1);

        // Early-error masking and error-to-decision latency
        do_reset();
        request(2'b01);
        for (int k = 1; k <= 103; k++) begin
            if (k == 3) cfg_ERROR = 1'b1;
            if (k == 7) cfg_ERROR = 1'b0;
            if (k == 10) check("mask_setup_retry", retry_cnt, 2'd0);
            if (k == 81) begin
                check("mask_wait_retry",  retry_cnt,  2'd0);
                check("mask_wait_ena",    cfg_ENA,    1'b1);
                check("mask_wait_config", cfg_CONFIG, 1'b0);
            end
            if (k == 102) check("lat_2_retry", retry_cnt, 2'd0);
            if (k == 103) begin
                check("lat_3_retry", retry_cnt, 2'd1);
                check("lat_3_cbsel", cfg_CBSEL, 2'b01);
            end
            if (k == 100) cfg_ERROR = 1'b1;
            if (k < 103) @(negedge clk);
        end
        cfg_ERROR = 1'b0;

        // Retries then fallback, reset in cycle 30 of the first golden pulse
        do_reset();
        cfg_ERROR = 1'b1;
        request(2'b10);
        run_pulses(1000, 4, 30, to);
        check("fb_timeout", to, 1'b0);
        check("fb_p0_sel", p_sel[0], 2'b10); check("fb_p0_rty", p_rty[0], 2'd0); check("fb_p0_fb", p_fb[0], 1'b0);
        check("fb_p1_sel", p_sel[1], 2'b10); check("fb_p1_rty", p_rty[1], 2'd1); check("fb_p1_fb", p_fb[1], 1'b0);
        check("fb_p2_sel", p_sel[2], 2'b10); check("fb_p2_rty", p_rty[2], 2'd2); check("fb_p2_fb", p_fb[2], 1'b0);
        check("fb_p3_sel", p_sel[3], 2'b00); check("fb_p3_rty", p_rty[3], 2'd0); check("fb_p3_fb", p_fb[3], 1'b1);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_config",   cfg_CONFIG, 1'b0);
        check("mid_rst_ena",      cfg_ENA,    1'b0);
        check("mid_rst_cbsel",    cfg_CBSEL,  2'b00);
        check("mid_rst_ready",    req_ready,  1'b1);
        check("mid_rst_fallback", fallback,   1'b0);
        check("mid_rst_retry",    retry_cnt,  2'd0);
        rst = 1'b0;

        // Full chain ending in terminal failure
        do_reset();
        cfg_ERROR = 1'b1;
        request(2'b10);
        run_pulses(2000, 0, 0, to);
        check("gf_timeout", to, 1'b0);
        check("gf_npulses", np, 6);
        check("gf_p4_sel", p_sel[4], 2'b00); check("gf_p4_rty", p_rty[4], 2'd1);
        check("gf_p5_sel", p_sel[5], 2'b00); check("gf_p5_rty", p_rty[5], 2'd2); check("gf_p5_fb", p_fb[5], 1'b1);
        req_valid = 1'b1;
        req_sel   = 2'b01;
        repeat (20) @(negedge clk);
        check("gf_ready",    req_ready,  1'b0);
        check("gf_busy",     busy,       1'b1);
        check("gf_ena",      cfg_ENA,    1'b0);
        check("gf_config",   cfg_CONFIG, 1'b0);
        check("gf_fail",     fail,       1'b1);
        check("gf_fallback", fallback,   1'b1);
        check("gf_cbsel",    cfg_CBSEL,  2'b00);
        req_valid = 1'b0;
        do_reset();
        check("gf_rst_fail",     fail,      1'b0);
        check("gf_rst_fallback", fallback,  1'b0);
        check("gf_rst_ready",    req_ready, 1'b1);

        // Golden image requested directly: no fallback, straight to fail
        cfg_ERROR = 1'b1;
        request(2'b00);
        run_pulses(1000, 0, 0, to);
        check("gd_timeout", to, 1'b0);
        check("gd_npulses", np, 3);
        check("gd_p0_sel", p_sel[0], 2'b00);
        check("gd_p2_rty", p_rty[2], 2'd2);
        check("gd_fallback", fallback, 1'b0);
        check("gd_fail",     fail,     1'b1);
        check("gd_ena",      cfg_ENA,  1'b0);
        cfg_ERROR = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
